// File: rtl/cacheline_line_buffer_if.sv
// Signal bundle between the LLC controller, the line buffer and the external memory port.
// The buffer connects through the slave modport; the LLC/memory environment uses master.
interface cacheline_line_buffer_if #(
  parameter int XLEN           = 32,
  parameter int CACHELINE_SIZE = 256,
  parameter int BURST_WIDTH    = 64
);
  logic                      line_read_i;
  logic                      line_write_i;
  logic [XLEN-1:0]           line_addr_i;
  logic [CACHELINE_SIZE-1:0] line_wdata_i;
  logic                      line_ready_o;
  logic [CACHELINE_SIZE-1:0] line_rdata_o;
  logic                      line_rvalid_o;
  logic                      line_wdone_o;
  logic                      mem_read_o;
  logic                      mem_write_o;
  logic [XLEN-1:0]           mem_addr_o;
  logic [BURST_WIDTH-1:0]    mem_wdata_o;
  logic                      mem_ready_i;
  logic [BURST_WIDTH-1:0]    mem_rdata_i;
  logic                      mem_rvalid_i;

  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  mem_ready_i, mem_rdata_i, mem_rvalid_i,
    output line_ready_o, line_rdata_o, line_rvalid_o, line_wdone_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output mem_ready_i, mem_rdata_i, mem_rvalid_i,
    input  line_ready_o, line_rdata_o, line_rvalid_o, line_wdone_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/cacheline_line_buffer.sv
// Cache-line buffer: serializes LLC writebacks into memory bursts and assembles read bursts into lines.
// Optional writeback-to-read forwarding is enabled by defining LINE_BUFFER_WRITE_FORWARD_EN.
module cacheline_line_buffer #(
  parameter int XLEN           = 32,
  parameter int CACHELINE_SIZE = 256,
  parameter int BURST_WIDTH    = 64
) (
  input logic                    clk,
  input logic                    rst,
  cacheline_line_buffer_if.slave bus
);
  localparam int BEATS = CACHELINE_SIZE / BURST_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0]   LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-5){1'b1}}, 5'b0};

  typedef enum logic [2:0] {
    LINE_IDLE,
    WAIT,
    SERIALIZE,
    DESERIALIZE,
    DESERIALIZE_DONE
  } line_buffer_state_t;

  line_buffer_state_t        state;
  logic [CW-1:0]             cnt;
  logic [XLEN-1:0]           addr;
  logic [CACHELINE_SIZE-1:0] rdata;
  logic [CACHELINE_SIZE-1:0] wbuf;
  logic [BURST_WIDTH-1:0]    wbeat;
  logic                      ready;
  logic                      mem_read;
  logic                      mem_write;
  logic                      rvalid;
  logic                      wdone;

  logic [XLEN-1:0] aligned;
  logic            accept_wr;
  logic            beat_wr;

  assign aligned   = bus.line_addr_i & ALIGN_MASK;
  assign accept_wr = (state == LINE_IDLE) && bus.line_write_i;
  assign beat_wr   = (state == SERIALIZE) && bus.mem_ready_i;

`ifdef LINE_BUFFER_WRITE_FORWARD_EN
  logic                      fwd_valid;
  logic [XLEN-1:0]           fwd_addr;
  logic [CACHELINE_SIZE-1:0] fwd_data;
  logic                      fwd_hit;

  assign fwd_hit = fwd_valid && (fwd_addr == aligned);
`endif

  // Write-side data storage: the remaining beats shift down so the next beat is always at the bottom
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      wbuf <= bus.line_wdata_i >> BURST_WIDTH;
    end else if (beat_wr) begin
      wbuf <= wbuf >> BURST_WIDTH;
    end
`ifdef LINE_BUFFER_WRITE_FORWARD_EN
    if (accept_wr) begin
      fwd_addr <= aligned;
      fwd_data <= bus.line_wdata_i;
    end
`endif
  end

  // Sequencer with registered outputs; a write wins over a simultaneous read
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LINE_IDLE;
      cnt       <= '0;
      addr      <= '0;
      rdata     <= '0;
      wbeat     <= '0;
      ready     <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rvalid    <= 1'b0;
      wdone     <= 1'b0;
`ifdef LINE_BUFFER_WRITE_FORWARD_EN
      fwd_valid <= 1'b0;
`endif
    end else begin
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      unique case (state)
        LINE_IDLE: begin
          if (bus.line_write_i) begin
            state     <= SERIALIZE;
            ready     <= 1'b0;
            mem_write <= 1'b1;
            addr      <= aligned;
            cnt       <= '0;
            wbeat     <= bus.line_wdata_i[BURST_WIDTH-1:0];
`ifdef LINE_BUFFER_WRITE_FORWARD_EN
            fwd_valid <= 1'b0;
`endif
          end else if (bus.line_read_i) begin
`ifdef LINE_BUFFER_WRITE_FORWARD_EN
            if (fwd_hit) begin
              state  <= DESERIALIZE_DONE;
              ready  <= 1'b0;
              rdata  <= fwd_data;
              rvalid <= 1'b1;
            end else begin
              state    <= WAIT;
              ready    <= 1'b0;
              mem_read <= 1'b1;
              addr     <= aligned;
            end
`else
            state    <= WAIT;
            ready    <= 1'b0;
            mem_read <= 1'b1;
            addr     <= aligned;
`endif
          end
        end
        WAIT: begin
          if (bus.mem_ready_i) begin
            state    <= DESERIALIZE;
            mem_read <= 1'b0;
            cnt      <= '0;
          end
        end
        DESERIALIZE: begin
          if (bus.mem_rvalid_i) begin
            for (int b = 0; b < BEATS; b++) begin
              if (cnt == CW'(b)) begin
                rdata[b*BURST_WIDTH +: BURST_WIDTH] <= bus.mem_rdata_i;
              end
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              state  <= DESERIALIZE_DONE;
              rvalid <= 1'b1;
            end
          end
        end
        DESERIALIZE_DONE: begin
          state <= LINE_IDLE;
          ready <= 1'b1;
        end
        SERIALIZE: begin
          if (bus.mem_ready_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              state     <= LINE_IDLE;
              ready     <= 1'b1;
              mem_write <= 1'b0;
              wbeat     <= '0;
              wdone     <= 1'b1;
`ifdef LINE_BUFFER_WRITE_FORWARD_EN
              fwd_valid <= 1'b1;
`endif
            end else begin
              wbeat <= wbuf[BURST_WIDTH-1:0];
            end
          end
        end
        default: begin
          state     <= LINE_IDLE;
          ready     <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.line_ready_o  = ready;
  assign bus.line_rdata_o  = rdata;
  assign bus.line_rvalid_o = rvalid;
  assign bus.line_wdone_o  = wdone;
  assign bus.mem_read_o    = mem_read;
  assign bus.mem_write_o   = mem_write;
  assign bus.mem_addr_o    = addr;
  assign bus.mem_wdata_o   = wbeat;
endmodule
